// File: rtl/sfx_sequencer_if.sv
// Bus between the game logic and the sound-effect sequencer: the frame
// strobe and collision levels in, the oscillator controls out.
interface sfx_sequencer_if;
  logic       frame_end;
  logic       sheep_hit;
  logic       sword_hit;
  logic       player_hit;
  logic [7:0] period;
  logic [3:0] volume;
  logic       tone_en;
  logic [1:0] sfx_id;

  // Game side: drives strobes/hits, listens to the oscillator controls.
  modport master (
    output frame_end, sheep_hit, sword_hit, player_hit,
    input  period, volume, tone_en, sfx_id
  );

  // Sequencer side.
  modport slave (
    input  frame_end, sheep_hit, sword_hit, player_hit,
    output period, volume, tone_en, sfx_id
  );
endinterface

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: plays one of three 4-note sound effects on a rising edge
// of a collision input. Notes advance on frame_end strobes; a higher
// priority effect (player > sword > sheep) may interrupt a playing one.
// Optional macro SFX_SEQUENCER_DECAY_EN: after the last note, fade the
// volume out by one step per frame in a RELEASE state instead of stopping.
module sfx_sequencer #(
  parameter int unsigned NOTE_SCALE = 1  // frame_end strobes per ROM unit, 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  sfx_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

  localparam logic [7:0] SCALE8 = 8'(NOTE_SCALE);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] period_q, period_d;
  logic [3:0] volume_q, volume_d;
  logic       tone_q, tone_d;
  logic [1:0] sfx_q, sfx_d;
  logic       sheep_prev_q, sword_prev_q, player_prev_q;
  logic       arm_q;

  logic [1:0]  ev_id;
  logic        accept;
  logic [11:0] ev_rom;
  logic [11:0] next_rom;

  // Effect ROM: {period[7:0], duration units[3:0]} indexed by effect and note.
  function automatic logic [11:0] rom(input logic [1:0] id, input logic [1:0] idx);
    logic [11:0] r;
    case ({id, idx})
      4'b0100: r = 12'h402;
      4'b0101: r = 12'h302;
      4'b0110: r = 12'h202;
      4'b0111: r = 12'h184;
      4'b1000: r = 12'h801;
      4'b1001: r = 12'h601;
      4'b1010: r = 12'h801;
      4'b1011: r = 12'h601;
      4'b1100: r = 12'hF04;
      4'b1101: r = 12'hD04;
      4'b1110: r = 12'hB04;
      4'b1111: r = 12'h904;
      default: r = 12'h000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] scaled(input logic [3:0] dur);
    return {4'd0, dur} * SCALE8;
  endfunction

  // Rising-edge detection with priority. arm_q stays low for the first
  // cycle after reset so the edge registers can load the true input levels;
  // a hit held high through reset therefore never looks like a new edge.
  always_comb begin
    ev_id = 2'd0;
    if (arm_q) begin
      if (bus.player_hit && !player_prev_q)     ev_id = 2'd3;
      else if (bus.sword_hit && !sword_prev_q)  ev_id = 2'd2;
      else if (bus.sheep_hit && !sheep_prev_q)  ev_id = 2'd1;
    end
    accept   = (ev_id != 2'd0) && ((state_q != PLAY) || (ev_id > sfx_q));
    ev_rom   = rom(ev_id, 2'd0);
    next_rom = rom(sfx_q, 2'(idx_q + 2'd1));
  end

  // Next-state and registered-output logic of the sequencer FSM.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    volume_d = volume_q;
    sfx_d    = sfx_q;
    if (accept) begin
      // A new event wins over any frame_end in the same cycle.
      state_d  = PLAY;
      idx_d    = 2'd0;
      cnt_d    = scaled(ev_rom[3:0]);
      period_d = ev_rom[11:4];
      volume_d = 4'd15;
      sfx_d    = ev_id;
    end else begin
      case (state_q)
        PLAY: begin
          if (bus.frame_end) begin
            if (cnt_q <= 8'd1) begin
              if (idx_q == 2'd3) begin
`ifdef SFX_SEQUENCER_DECAY_EN
                state_d = RELEASE;
                cnt_d   = 8'd0;
`else
                state_d  = IDLE;
                idx_d    = 2'd0;
                cnt_d    = 8'd0;
                period_d = 8'd0;
                volume_d = 4'd0;
                sfx_d    = 2'd0;
`endif
              end else begin
                idx_d    = 2'(idx_q + 2'd1);
                cnt_d    = scaled(next_rom[3:0]);
                period_d = next_rom[11:4];
              end
            end else begin
              cnt_d = 8'(cnt_q - 8'd1);
            end
          end
        end
        RELEASE: begin
`ifdef SFX_SEQUENCER_DECAY_EN
          if (bus.frame_end) begin
            if (volume_q <= 4'd1) begin
              state_d  = IDLE;
              idx_d    = 2'd0;
              period_d = 8'd0;
              volume_d = 4'd0;
              sfx_d    = 2'd0;
            end else begin
              volume_d = 4'(volume_q - 4'd1);
            end
          end
`else
          state_d  = IDLE;
          idx_d    = 2'd0;
          period_d = 8'd0;
          volume_d = 4'd0;
          sfx_d    = 2'd0;
`endif
        end
        default: begin
          state_d  = IDLE;
          period_d = 8'd0;
          volume_d = 4'd0;
          sfx_d    = 2'd0;
        end
      endcase
    end
    tone_d = (state_d != IDLE);
  end

  // State, outputs and edge registers; reset aborts any effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      cnt_q         <= 8'd0;
      period_q      <= 8'd0;
      volume_q      <= 4'd0;
      tone_q        <= 1'b0;
      sfx_q         <= 2'd0;
      sheep_prev_q  <= 1'b0;
      sword_prev_q  <= 1'b0;
      player_prev_q <= 1'b0;
      arm_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      volume_q      <= volume_d;
      tone_q        <= tone_d;
      sfx_q         <= sfx_d;
      sheep_prev_q  <= bus.sheep_hit;
      sword_prev_q  <= bus.sword_hit;
      player_prev_q <= bus.player_hit;
      arm_q         <= 1'b1;
    end
  end

  assign bus.period  = period_q;
  assign bus.volume  = volume_q;
  assign bus.tone_en = tone_q;
  assign bus.sfx_id  = sfx_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer (NOTE_SCALE = 1). Observed word is
// {period[7:0], volume[3:0], tone_en, sfx_id[1:0]}.
module tb_sfx_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   fails = 0;
  logic [14:0] got_v, exp_v;

  sfx_sequencer_if bus ();

  sfx_sequencer #(.NOTE_SCALE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] obs();
    return {bus.period, bus.volume, bus.tone_en, bus.sfx_id};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Nine quiet cycles then one frame_end strobe (frame every 10 cycles).
  task automatic frame();
    repeat (9) step();
    bus.frame_end = 1'b1;
    step();
    bus.frame_end = 1'b0;
  endtask

  task automatic do_reset();
    bus.frame_end = 1'b0; bus.sheep_hit = 1'b0;
    bus.sword_hit = 1'b0; bus.player_hit = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    got_v = obs(); exp_v = 15'h0; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL reset_state got %h exp %h", got_v, exp_v); end
  endtask

  task automatic test_sheep_sequence();
    logic [7:0] per [4];
    per[0] = 8'h40; per[1] = 8'h30; per[2] = 8'h20; per[3] = 8'h18;
    do_reset();
    bus.sheep_hit = 1'b1;
    step();
    bus.sheep_hit = 1'b0;
    got_v = obs(); exp_v = {8'h40, 4'd15, 1'b1, 2'd1}; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL sheep_start got %h exp %h", got_v, exp_v); end
    for (int n = 1; n < 4; n++) begin
      frame();
      got_v = obs(); exp_v = {per[n-1], 4'd15, 1'b1, 2'd1}; tests_run++;
      if (got_v !== exp_v) begin fails++; $display("FAIL sheep_hold%0d got %h exp %h", n, got_v, exp_v); end
      frame();
      got_v = obs(); exp_v = {per[n], 4'd15, 1'b1, 2'd1}; tests_run++;
      if (got_v !== exp_v) begin fails++; $display("FAIL sheep_note%0d got %h exp %h", n, got_v, exp_v); end
    end
    repeat (3) frame();
    got_v = obs(); exp_v = {8'h18, 4'd15, 1'b1, 2'd1}; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL sheep_last_hold got %h exp %h", got_v, exp_v); end
    frame();
`ifdef SFX_SEQUENCER_DECAY_EN
    exp_v = {8'h18, 4'd15, 1'b1, 2'd1};
`else
    exp_v = 15'h0;
`endif
    got_v = obs(); tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL sheep_end got %h exp %h", got_v, exp_v); end
  endtask

  task automatic test_priority();
    do_reset();
    bus.sheep_hit = 1'b1; bus.sword_hit = 1'b1; bus.player_hit = 1'b1;
    step();
    got_v = obs(); exp_v = {8'hF0, 4'd15, 1'b1, 2'd3}; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL priority_all got %h exp %h", got_v, exp_v); end
  endtask

  task automatic test_preempt();
    do_reset();
    bus.player_hit = 1'b1;
    step();
    bus.sword_hit = 1'b1;
    step(); step();
    got_v = obs(); exp_v = {8'hF0, 4'd15, 1'b1, 2'd3}; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL lower_ignored got %h exp %h", got_v, exp_v); end
    do_reset();
    bus.sword_hit = 1'b1;
    step();
    got_v = obs(); exp_v = {8'h80, 4'd15, 1'b1, 2'd2}; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL sword_start got %h exp %h", got_v, exp_v); end
    frame();
    got_v = obs(); exp_v = {8'h60, 4'd15, 1'b1, 2'd2}; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL sword_note1 got %h exp %h", got_v, exp_v); end
    bus.player_hit = 1'b1;
    step();
    got_v = obs(); exp_v = {8'hF0, 4'd15, 1'b1, 2'd3}; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL player_restart got %h exp %h", got_v, exp_v); end
    frame();
    got_v = obs(); exp_v = {8'hF0, 4'd15, 1'b1, 2'd3}; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL player_restart_hold got %h exp %h", got_v, exp_v); end
  endtask

  task automatic test_event_with_frame();
    do_reset();
    bus.sheep_hit = 1'b1; bus.frame_end = 1'b1;
    step();
    bus.sheep_hit = 1'b0; bus.frame_end = 1'b0;
    got_v = obs(); exp_v = {8'h40, 4'd15, 1'b1, 2'd1}; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL evframe_start got %h exp %h", got_v, exp_v); end
    frame();
    got_v = obs(); tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL evframe_no_dec got %h exp %h", got_v, exp_v); end
    frame();
    got_v = obs(); exp_v = {8'h30, 4'd15, 1'b1, 2'd1}; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL evframe_advance got %h exp %h", got_v, exp_v); end
  endtask

  task automatic test_sword_end();
    logic [7:0] per [4];
    per[0] = 8'h80; per[1] = 8'h60; per[2] = 8'h80; per[3] = 8'h60;
    do_reset();
    bus.sword_hit = 1'b1;
    step();
    bus.sword_hit = 1'b0;
    for (int n = 1; n < 4; n++) begin
      frame();
      got_v = obs(); exp_v = {per[n], 4'd15, 1'b1, 2'd2}; tests_run++;
      if (got_v !== exp_v) begin fails++; $display("FAIL sword_seq%0d got %h exp %h", n, got_v, exp_v); end
    end
    frame();
`ifdef SFX_SEQUENCER_DECAY_EN
    got_v = obs(); exp_v = {8'h60, 4'd15, 1'b1, 2'd2}; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL sword_release got %h exp %h", got_v, exp_v); end
    for (int i = 1; i <= 15; i++) begin
      frame();
      got_v = obs();
      exp_v = (i < 15) ? {8'h60, 4'(15 - i), 1'b1, 2'd2} : 15'h0;
      tests_run++;
      if (got_v !== exp_v) begin fails++; $display("FAIL sword_decay%0d got %h exp %h", i, got_v, exp_v); end
    end
`else
    got_v = obs(); exp_v = 15'h0; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL sword_idle got %h exp %h", got_v, exp_v); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.player_hit = 1'b1;
    step();
    frame();
    #2 rst_n = 1'b0;
    #1;
    got_v = obs(); exp_v = 15'h0; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL async_reset got %h exp %h", got_v, exp_v); end
    step();
    #2 rst_n = 1'b1;
    repeat (3) step();
    got_v = obs(); tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL held_no_trigger got %h exp %h", got_v, exp_v); end
    bus.player_hit = 1'b0;
    step();
    bus.player_hit = 1'b1;
    step();
    got_v = obs(); exp_v = {8'hF0, 4'd15, 1'b1, 2'd3}; tests_run++;
    if (got_v !== exp_v) begin fails++; $display("FAIL fresh_edge got %h exp %h", got_v, exp_v); end
  endtask

  initial begin
    bus.frame_end = 1'b0; bus.sheep_hit = 1'b0;
    bus.sword_hit = 1'b0; bus.player_hit = 1'b0;
    test_reset();
    test_sheep_sequence();
    test_priority();
    test_preempt();
    test_event_with_frame();
    test_sword_end();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
